conv_window_feeder: RTL and testbench

//  Streams raster-ordered pixels of NUM_CH feature maps (one pixel per channel per beat) into K-1 line buffers.

---
 rtl/conv_window_feeder_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 39 +++
 rtl/conv_window_feeder.sv | 132 +++++++++++++
 tb/tb_conv_window_feeder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the C3 window feeder and the conv stage wiring.
// Holds the default geometry of the C3 stage (pixel width, map size, channel
// count, kernel size). It also holds the column packing function. That function
// maps (channel, row) to the bit offset inside a packed K-tall column. Row 0 is
// the top (oldest) pixel.
package conv_window_feeder_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_MAP_W     = 14;
  localparam int DEF_MAP_H     = 14;
  localparam int DEF_NUM_CH    = 6;
  localparam int DEF_K         = 5;

  // Bit offset of channel c, row r in a column of k rows of bw-bit pixels.
  function automatic int col_offset(input int c, input int r, input int k, input int bw);
    return (c * k + r) * bw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: ROWS line buffers of DEPTH entries, each WIDTH bits.
// A write at addr pushes wdata into row 0. On the same edge, the previous
// contents of that column move down one row (row i takes row i-1). The read
// port is combinational at the same addr. It returns the pre-write contents,
// which form the upper part of the current column. The storage has no reset.
// Ports:
//   clk    in   clock
//   we     in   write/shift enable for column addr
//   addr   in   column index
//   wdata  in   newest pixel word for column addr
//   rdata  out  rdata[i] = row i at addr (row 0 = most recent line)
module conv_line_buffer #(
  parameter int ROWS  = 4,
  parameter int DEPTH = 14,
  parameter int WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]           wdata,
  output logic [ROWS-1:0][WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS][DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][addr] <= wdata;
      for (int i = 1; i < ROWS; i++) begin
        mem[i][addr] <= mem[i-1][addr];
      end
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_rd
    assign rdata[i] = mem[i][addr];
  end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a raster stream of NUM_CH feature maps into
// K-tall pixel columns for the column-shifting C3 convolution datapath.
// Each column is flagged when it completes a full KxK window.
//
// Handshake: in_valid only, with no ready. Every cycle with in_valid high is
// an accepted beat. Each accepted beat produces exactly one registered
// output one cycle later. A cycle with in_valid low changes no state.
// In the cycle that follows it, out_en, win_valid and frame_done are low.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     input beat valid
//   in_sof       with in_valid: this beat is pixel (0,0)
//   in_pix       channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   out_en       column valid (conv stage enable)
//   out_column   ch c, row r (0 = top) at col_offset(c, r, K, BIT_WIDTH)
//   win_valid    out_en and the column completes a KxK window
//   out_x/out_y  window origin (x-(K-1), y-(K-1)); valid with win_valid
//   frame_done   pulse with the column of the last pixel of a frame
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int MAP_W     = DEF_MAP_W,
  parameter int MAP_H     = DEF_MAP_H,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int K         = DEF_K
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [NUM_CH*BIT_WIDTH-1:0]     in_pix,
  output logic                            out_en,
  output logic [NUM_CH*K*BIT_WIDTH-1:0]   out_column,
  output logic                            win_valid,
  output logic [$clog2(MAP_W)-1:0]        out_x,
  output logic [$clog2(MAP_H)-1:0]        out_y,
  output logic                            frame_done
);

  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int PW = NUM_CH * BIT_WIDTH;
  localparam int CW = NUM_CH * K * BIT_WIDTH;

  localparam logic [XW-1:0] X_LAST = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MAP_H - 1);
  localparam logic [XW-1:0] X_FULL = XW'(K - 1);
  localparam logic [YW-1:0] Y_FULL = YW'(K - 1);

  logic [XW-1:0]          x_q, cur_x;
  logic [YW-1:0]          y_q, cur_y;
  logic [K-2:0][PW-1:0]   lb_rd;
  logic [CW-1:0]          col_next;
  logic                   rows_full, cols_full, last_pix;

  // in_sof overrides the counters for this beat only.
  assign cur_x     = in_sof ? '0 : x_q;
  assign cur_y     = in_sof ? '0 : y_q;
  // The line buffers hold K-1 valid rows of the current frame only from
  // row K-1 on. Earlier rows may carry stale data from an aborted frame, a
  // previous frame or uninitialised RAM, so they are never emitted.
  assign rows_full = (cur_y >= Y_FULL);
  assign cols_full = (cur_x >= X_FULL);
  assign last_pix  = (cur_x == X_LAST) && (cur_y == Y_LAST);

  conv_line_buffer #(
    .ROWS  (K - 1),
    .DEPTH (MAP_W),
    .WIDTH (PW)
  ) u_lb (
    .clk   (clk),
    .we    (in_valid),
    .addr  (cur_x),
    .wdata (in_pix),
    .rdata (lb_rd)
  );

  // Column assembly. The oldest line (lb row K-2) goes on top and the
  // incoming pixel goes at the bottom.
  always_comb begin
    col_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < K - 1; r++) begin
        col_next[col_offset(c, r, K, BIT_WIDTH) +: BIT_WIDTH] =
          lb_rd[K-2-r][c*BIT_WIDTH +: BIT_WIDTH];
      end
      col_next[col_offset(c, K - 1, K, BIT_WIDTH) +: BIT_WIDTH] =
        in_pix[c*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_valid) begin
      if (cur_x == X_LAST) begin
        x_q <= '0;
        y_q <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_q <= cur_x + 1'b1;
        y_q <= cur_y;
      end
    end
  end

  // Registered outputs. The column and the window coordinates update only
  // on beats that emit a column, so they hold their values otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en     <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_column <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_en     <= in_valid && rows_full;
      win_valid  <= in_valid && rows_full && cols_full;
      frame_done <= in_valid && last_pix;
      if (in_valid && rows_full) begin
        out_column <= col_next;
        out_x      <= cur_x - X_FULL;
        out_y      <= cur_y - Y_FULL;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;

  localparam int BW   = 8;
  localparam int MW   = 14;
  localparam int MH   = 14;
  localparam int NC   = 6;
  localparam int KK   = 5;
  localparam int PW   = NC * BW;
  localparam int CW   = NC * KK * BW;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int NPIX = MW * MH;
  localparam int NWX  = MW - KK + 1;
  localparam int NWY  = MH - KK + 1;
  localparam int EW   = 3 + XW + YW + CW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sof;
  logic [PW-1:0] in_pix;
  logic out_en, win_valid, frame_done;
  logic [CW-1:0] out_column;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  always #5 clk = ~clk;

  conv_window_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .out_en     (out_en),
    .out_column (out_column),
    .win_valid  (win_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  // ---------------- reference model state ----------------
  // The model keeps the current frame as an image and derives each column
  // from image rows y-(K-1)..y at column x.
  logic [BW-1:0] img [MH][MW][NC];
  int            mpos;
  logic [CW-1:0] last_col;
  logic [EW-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  // run statistics gathered from DUT outputs, compared against constants
  int             acc_beats, first_en, win_cnt, fd_cnt, fd_beat;
  logic [KK*BW-1:0] first_col0;
  int             rec_sel;
  logic [CW-1:0]  seq_a[$];
  logic [CW-1:0]  seq_b[$];
  bit             cap_en;
  logic [KK*BW-1:0] cap [NWY][NWX];

  typedef struct packed {
    logic [XW-1:0]    ox;
    logic [YW-1:0]    oy;
    logic [KK*BW-1:0] col0;
  } win_vec_t;

  win_vec_t tbl [4];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ch0 column from top (t0) to bottom (t4)
  function automatic logic [KK*BW-1:0] col5(input int t0, input int t1, input int t2,
                                            input int t3, input int t4);
    return {BW'(t4), BW'(t3), BW'(t2), BW'(t1), BW'(t0)};
  endfunction

  // mode 0: c*16+y   mode 1: ramp x+y*MW (+c*50)   mode 2: negated ramp   else random
  function automatic logic [PW-1:0] pixel(input int mode, input int x, input int y);
    logic [PW-1:0] v;
    logic [BW-1:0] b;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      case (mode)
        0:       b = BW'(c * 16 + y);
        1:       b = BW'(x + y * MW + c * 50);
        2:       b = -BW'(x + y * MW + c * 50);
        default: b = BW'($urandom);
      endcase
      v[c*BW +: BW] = b;
    end
    return v;
  endfunction

  task automatic model_reset();
    mpos     = 0;
    last_col = '0;
    exp_q.delete();
  endtask

  task automatic clear_stats();
    acc_beats  = 0;
    first_en   = 0;
    win_cnt    = 0;
    fd_cnt     = 0;
    fd_beat    = 0;
    first_col0 = '0;
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic beat(input logic v, input logic s, input logic [PW-1:0] pix);
    int p, x, y;
    logic e_en, e_win, e_fd;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic [CW-1:0] e_col;
    logic [EW-1:0] e;
    e_en = 1'b0; e_win = 1'b0; e_fd = 1'b0; e_x = '0; e_y = '0; e_col = last_col;
    if (v) begin
      p = s ? 0 : mpos;
      x = p % MW;
      y = p / MW;
      if (y >= KK - 1) begin
        e_en  = 1'b1;
        e_win = (x >= KK - 1);
        e_x   = XW'(x - (KK - 1));
        e_y   = YW'(y - (KK - 1));
        for (int c = 0; c < NC; c++) begin
          for (int r = 0; r < KK - 1; r++)
            e_col[(c*KK + r)*BW +: BW] = img[y-(KK-1)+r][x][c];
          e_col[(c*KK + KK - 1)*BW +: BW] = pix[c*BW +: BW];
        end
        last_col = e_col;
      end
      e_fd = (p == NPIX - 1);
      for (int c = 0; c < NC; c++) img[y][x][c] = pix[c*BW +: BW];
      mpos = (p + 1) % NPIX;
      acc_beats++;
    end
    exp_q.push_back({e_fd, e_win, e_en, e_x, e_y, e_col});

    in_valid = v;
    in_sof   = s;
    in_pix   = pix;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("flags", 256'({frame_done, win_valid, out_en}), 256'(e[EW-1 -: 3]));
    check("column", 256'(out_column), 256'(e[CW-1:0]));
    if (e[EW-2]) check("window_xy", 256'({out_x, out_y}), 256'(e[CW +: XW+YW]));

    if (out_en && first_en == 0) begin
      first_en   = acc_beats;
      first_col0 = out_column[KK*BW-1:0];
    end
    if (win_valid) begin
      win_cnt++;
      if (rec_sel == 1) seq_a.push_back(out_column);
      if (rec_sel == 2) seq_b.push_back(out_column);
      if (cap_en && out_x < XW'(NWX) && out_y < YW'(NWY))
        cap[out_y][out_x] = out_column[KK*BW-1:0];
    end
    if (frame_done) begin
      fd_cnt++;
      fd_beat = acc_beats;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, PW'({$urandom, $urandom}));
  endtask

  task automatic send_pixels(input int mode, input int n, input bit sof_first, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int p;
      p = i % NPIX;
      beat(1'b1, (i == 0) && sof_first, pixel(mode, p % MW, p / MW));
      if (gaps) idle(1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int mism;
    logic v, s;

    tbl[0] = '{ox: 4'd0, oy: 4'd0, col0: col5(4, 18, 32, 46, 60)};
    // ramp at x=13, rows 9..13: 13 + y*14
    tbl[1] = '{ox: 4'd9, oy: 4'd9, col0: col5(139, 153, 167, 181, 195)};
    tbl[2] = '{ox: 4'd5, oy: 4'd2, col0: col5(37, 51, 65, 79, 93)};
    tbl[3] = '{ox: 4'd3, oy: 4'd7, col0: col5(105, 119, 133, 147, 161)};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    rec_sel = 0; cap_en = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 256'({out_en, win_valid, frame_done, out_x, out_y, out_column}), 256'(0));
    rst = 1'b0;

    // 1: channel/row pattern, one frame
    clear_stats();
    send_pixels(0, NPIX, 1'b1, 1'b0);
    check("t1_first_en_beat", 256'(first_en), 256'(57));
    check("t1_first_col_ch0", 256'(first_col0), 256'(col5(0, 1, 2, 3, 4)));
    check("t1_win_count", 256'(win_cnt), 256'(100));
    check("t1_frame_done_count", 256'(fd_cnt), 256'(1));
    check("t1_frame_done_beat", 256'(fd_beat), 256'(196));
    idle(3);

    // 2: ramp frame, windows captured and checked against the table
    clear_stats();
    rec_sel = 1; cap_en = 1'b1;
    send_pixels(1, NPIX, 1'b1, 1'b0);
    rec_sel = 0; cap_en = 1'b0;
    check("t2_win_count", 256'(win_cnt), 256'(100));
    for (int i = 0; i < 4; i++)
      check("t2_window_col0", 256'(cap[tbl[i].oy][tbl[i].ox]), 256'(tbl[i].col0));

    // 3: same ramp with a gap after every beat
    clear_stats();
    rec_sel = 2;
    send_pixels(1, NPIX, 1'b1, 1'b1);
    rec_sel = 0;
    check("t3_win_count", 256'(win_cnt), 256'(100));
    check("t3_seq_len", 256'(seq_b.size()), 256'(seq_a.size()));
    mism = 0;
    for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
      if (seq_a[i] !== seq_b[i]) mism++;
    check("t3_seq_equal", 256'(mism), 256'(0));

    // 4: back-to-back frames, the second one negated
    clear_stats();
    send_pixels(1, NPIX, 1'b1, 1'b0);
    first_en = 0; acc_beats = 0;
    send_pixels(2, NPIX, 1'b1, 1'b0);
    check("t4_second_first_en", 256'(first_en), 256'(57));
    check("t4_win_count", 256'(win_cnt), 256'(200));
    check("t4_frame_done_count", 256'(fd_cnt), 256'(2));
    idle(2);

    // 5: in_sof at beat 100 aborts the running frame
    clear_stats();
    send_pixels(3, 99, 1'b1, 1'b0);
    check("t5_no_abort_done", 256'(fd_cnt), 256'(0));
    acc_beats = 0; win_cnt = 0;
    send_pixels(3, NPIX, 1'b1, 1'b0);
    check("t5_frame_done_count", 256'(fd_cnt), 256'(1));
    check("t5_frame_done_beat", 256'(fd_beat), 256'(196));
    check("t5_win_count", 256'(win_cnt), 256'(100));

    // 6: asynchronous reset mid-frame, then a frame without in_sof
    clear_stats();
    send_pixels(3, 80, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t6_async_clear", 256'({out_en, win_valid, frame_done, out_x, out_y, out_column}), 256'(0));
    #1 rst = 1'b0;
    model_reset();
    clear_stats();
    send_pixels(3, NPIX, 1'b0, 1'b0);
    check("t6_frame_done_count", 256'(fd_cnt), 256'(1));
    check("t6_frame_done_beat", 256'(fd_beat), 256'(196));
    check("t6_win_count", 256'(win_cnt), 256'(100));

    // 7: random valid gaps, random pixels, occasional in_sof
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 149) == 0);
      beat(v, s, pixel(3, 0, 0));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
